// File: rtl/multdiv_unit_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// Holds the FSM encoding, iteration counts, Booth op encoding and a magnitude helper.
package multdiv_unit_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MULT    = 3'd1,
      S_DIV     = 3'd2,
      S_SIGNFIX = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      BOOTH_NOP = 3'd0,
      BOOTH_PA  = 3'd1,
      BOOTH_P2A = 3'd2,
      BOOTH_MA  = 3'd3,
      BOOTH_M2A = 3'd4
   } booth_op_t;

   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] MULT_ITERS = 6'd16;
   localparam logic [CNT_W-1:0] DIV_ITERS  = 6'd32;

   // 0x80000000 maps onto itself, which is the correct unsigned magnitude 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/level2_cla.sv
// 32-bit two-level carry-lookahead adder: 4-bit groups, group carries resolved at the second level.
// ovf reports signed overflow of a + b + cin.
module level2_cla (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout,
   output logic        ovf
);

   logic [31:0] g, p, c;
   logic [7:0]  gg, gp;
   logic [8:0]  gc;

   always_comb begin
      g = a & b;
      p = a ^ b;
      for (int i = 0; i < 8; i++) begin
         gp[i] = &p[4*i +: 4];
         gg[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      end
      gc[0] = cin;
      for (int i = 0; i < 8; i++) begin
         gc[i+1] = gg[i] | (gp[i] & gc[i]);
      end
      for (int i = 0; i < 8; i++) begin
         c[4*i] = gc[i];
         for (int j = 1; j < 4; j++) begin
            c[4*i+j] = g[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
         end
      end
      sum  = p ^ c;
      cout = gc[8];
      ovf  = c[31] ^ gc[8];
   end

endmodule

// File: rtl/multdiv_booth_dec.sv
// Radix-4 modified Booth decoder: maps {lo[1:0], q-1} onto the adder controls.
// sel_2a picks 2A over A, invert negates the addend (with Cin=1), zero forces a NOP.
module multdiv_booth_dec
   import multdiv_unit_pkg::*;
(
   input  logic [2:0] triplet,
   output logic       sel_2a,
   output logic       invert,
   output logic       zero
);

   booth_op_t op;

   always_comb begin
      case (triplet)
         3'b001, 3'b010: op = BOOTH_PA;
         3'b011:         op = BOOTH_P2A;
         3'b100:         op = BOOTH_M2A;
         3'b101, 3'b110: op = BOOTH_MA;
         default:        op = BOOTH_NOP;
      endcase
      sel_2a = (op == BOOTH_P2A) || (op == BOOTH_M2A);
      invert = (op == BOOTH_MA)  || (op == BOOTH_M2A);
      zero   = (op == BOOTH_NOP);
   end

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed 32-bit multiplier (radix-4 Booth) / divider (non-restoring) sharing one CLA adder.
// Handshake: a one-cycle ctrl_MULT/ctrl_DIV pulse starts (or restarts) an op; data_resultRDY pulses once when done.
module multdiv_unit
   import multdiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter logic [31:0] DIV0_RESULT = 32'h00000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;

   // Multiply: {acc_hi, acc_lo, acc_x} = {hi, lo, q-1}.
   // Divide: {acc_x, acc_hi} = 33-bit remainder, acc_lo = dividend shifting out / quotient shifting in.
   logic [31:0] acc_hi, acc_lo, opd;
   logic        acc_x, sign, div0;
   logic [31:0] result_q;
   logic        exc_q;

   logic [31:0] cla_a, cla_b, cla_sum, m_base, m_add;
   logic        cla_cin, cla_cout, cla_ovf_unused;
   logic        sel_2a, invert, zero;
   logic [1:0]  m_ext, m_top;
   logic        d_top;

   multdiv_booth_dec u_booth (
      .triplet ({acc_lo[1:0], acc_x}),
      .sel_2a  (sel_2a),
      .invert  (invert),
      .zero    (zero)
   );

   level2_cla u_cla (
      .a    (cla_a),
      .b    (cla_b),
      .cin  (cla_cin),
      .sum  (cla_sum),
      .cout (cla_cout),
      .ovf  (cla_ovf_unused)
   );

   // Bits 33:32 of the partial sum are rebuilt from the carry so hi +/- 2A never wraps.
   always_comb begin
      m_base  = sel_2a ? {opd[30:0], 1'b0} : opd;
      m_add   = zero ? 32'd0 : (invert ? ~m_base : m_base);
      m_ext   = zero ? 2'b00 : {2{opd[31] ^ invert}};
      m_top   = {2{acc_hi[31]}} + m_ext + {1'b0, cla_cout};
      d_top   = acc_hi[31] ^ ~acc_x ^ cla_cout;
      cla_a   = '0;
      cla_b   = '0;
      cla_cin = 1'b0;
      case (state)
         S_MULT: begin
            cla_a   = acc_hi;
            cla_b   = m_add;
            cla_cin = invert & ~zero;
         end
         S_DIV: begin
            cla_a   = {acc_hi[30:0], acc_lo[31]};
            cla_b   = acc_x ? opd : ~opd;
            cla_cin = ~acc_x;
         end
         S_SIGNFIX: begin
            cla_a   = ~acc_lo;
            cla_cin = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ctrl_MULT)     state_nxt = S_MULT;
      else if (ctrl_DIV) state_nxt = S_DIV;
      else begin
         case (state)
            S_MULT:    if (cnt == MULT_ITERS) state_nxt = S_DONE;
            S_DIV:     if (div0) state_nxt = S_DONE;
                       else if (cnt == DIV_ITERS) state_nxt = S_SIGNFIX;
            S_SIGNFIX: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      data_resultRDY = (state == S_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_hi   <= '0;
         acc_lo   <= '0;
         acc_x    <= 1'b0;
         opd      <= '0;
         sign     <= 1'b0;
         div0     <= 1'b0;
         cnt      <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else if (ctrl_MULT) begin
         opd    <= data_operandA;
         acc_hi <= '0;
         acc_lo <= data_operandB;
         acc_x  <= 1'b0;
         cnt    <= '0;
      end else if (ctrl_DIV) begin
         opd    <= abs32(data_operandB);
         acc_hi <= '0;
         acc_lo <= abs32(data_operandA);
         acc_x  <= 1'b0;
         sign   <= data_operandA[31] ^ data_operandB[31];
         div0   <= (data_operandB == 32'd0);
         cnt    <= '0;
      end else begin
         case (state)
            S_MULT: begin
               if (cnt == MULT_ITERS) begin
                  result_q <= acc_lo;
                  exc_q    <= (acc_hi != {32{acc_lo[31]}});
               end else begin
                  acc_hi <= {m_top, cla_sum[31:2]};
                  acc_lo <= {cla_sum[1:0], acc_lo[31:2]};
                  acc_x  <= acc_lo[1];
                  cnt    <= cnt + 6'd1;
               end
            end
            S_DIV: begin
               if (div0) begin
                  result_q <= DIV0_RESULT;
                  exc_q    <= 1'b1;
               end else if (cnt != DIV_ITERS) begin
                  acc_x  <= d_top;
                  acc_hi <= cla_sum;
                  acc_lo <= {acc_lo[30:0], ~d_top};
                  cnt    <= cnt + 6'd1;
               end
            end
            S_SIGNFIX: begin
               // A positive quotient with bit 31 set only arises from 0x80000000 / -1.
               result_q <= sign ? cla_sum : acc_lo;
               exc_q    <= ~sign & acc_lo[31];
            end
            default: ;
         endcase
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: multiply, divide, div-by-zero, restart and async reset.
// Expected values are hand-computed constants; results are checked through one task.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drives one start pulse; the edge after the first negedge is E0.
   task automatic launch(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = mul;
      ctrl_DIV      = div;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   // Watches 40 edges after E0; elat=0 means no RDY may appear at all.
   task automatic watch(input string tag, input int elat, input logic [31:0] er, input logic ee);
      int first;
      int hits;
      logic [31:0] got_r;
      logic got_e;
      first = 0;
      hits  = 0;
      got_r = '0;
      got_e = 1'b0;
      if (elat > 0) exp_q.push_back(er);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            hits++;
            if (first == 0) begin
               first = k;
               got_r = data_result;
               got_e = data_exception;
            end
         end
      end
      check({tag, ".rdy_count"}, hits, (elat > 0) ? 32'd1 : 32'd0);
      if (elat > 0) begin
         check({tag, ".latency"}, first, elat);
         check({tag, ".result"}, got_r, exp_q.pop_front());
         check({tag, ".exception"}, {31'd0, got_e}, {31'd0, ee});
         check({tag, ".hold"}, data_result, er);
      end
   endtask

   initial begin
      int hits;
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset.result", data_result, 32'd0);
      check("reset.exception", {31'd0, data_exception}, 32'd0);
      check("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
      reset = 1'b0;

      launch(1, 0, 32'd7, 32'hFFFFFFFD);          watch("mul_7_m3", 17, 32'hFFFFFFEB, 1'b0);
      launch(1, 0, 32'h00010000, 32'h00010000);   watch("mul_2p32", 17, 32'h00000000, 1'b1);
      launch(1, 0, 32'h7FFFFFFF, 32'd1);          watch("mul_max_1", 17, 32'h7FFFFFFF, 1'b0);
      launch(1, 0, 32'h80000000, 32'hFFFFFFFF);   watch("mul_min_m1", 17, 32'h80000000, 1'b1);
      launch(1, 0, 32'h80000000, 32'd2);          watch("mul_min_2", 17, 32'h00000000, 1'b1);
      launch(1, 0, 32'hFFFFFFF9, 32'hFFFFFFF8);   watch("mul_m7_m8", 17, 32'd56, 1'b0);
      launch(1, 1, 32'd6, 32'd7);                 watch("both_ctrl", 17, 32'd42, 1'b0);

      launch(0, 1, 32'hFFFFFF9C, 32'd7);          watch("div_m100_7", 34, 32'hFFFFFFF2, 1'b0);
      launch(0, 1, 32'd100, 32'hFFFFFFF9);        watch("div_100_m7", 34, 32'hFFFFFFF2, 1'b0);
      launch(0, 1, 32'd7, 32'd100);               watch("div_7_100", 34, 32'd0, 1'b0);
      launch(0, 1, 32'hFFFFFFF9, 32'd2);          watch("div_m7_2", 34, 32'hFFFFFFFD, 1'b0);
      launch(0, 1, 32'd5, 32'd0);                 watch("div_by_0", 1, 32'd0, 1'b1);
      launch(0, 1, 32'h80000000, 32'hFFFFFFFF);   watch("div_min_m1", 34, 32'h80000000, 1'b1);

      // Multiply started, then a divide pulse lands on E8.
      launch(1, 0, 32'd3, 32'd4);
      hits = 0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) hits++;
      end
      check("restart.early_rdy", hits, 32'd0);
      launch(0, 1, 32'd20, 32'd5);
      watch("restart", 34, 32'd4, 1'b0);

      // Async reset between edges in the middle of a divide.
      launch(0, 1, 32'd100, 32'd7);
      repeat (10) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("midreset.result", data_result, 32'd0);
      check("midreset.exception", {31'd0, data_exception}, 32'd0);
      check("midreset.rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      watch("post_reset", 0, 32'd0, 1'b0);
      launch(1, 0, 32'd6, 32'd7);
      watch("mul_6_7", 17, 32'd42, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
